// File: rtl/pipe_height_gen.sv
// -----------------------------------------------------------------------------
// pipe_height_gen
//
// Holds a NUM_PIPES-deep queue of pipe top-edge Y coordinates (index 0 is the
// pipe nearest the bird). An advance shifts the queue and appends a new tail
// height, chosen by a deterministic rotation or a 16-bit Galois LFSR and
// slew-limited to MAX_DELTA levels from the previous tail. A load refills the
// whole queue deterministically starting from seed_idx.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   advance    one-cycle request to shift the queue
//   load       one-cycle request to refill the queue (wins over everything)
//   seed_idx   starting level for load, taken mod NUM_LEVELS
//   rand_mode  1 = LFSR levels, 0 = rotation; sampled in DRAW
//   pipe_y     packed heights, pipe k at [k*Y_W +: Y_W]
//   ready      high only while idle with no request in flight
//   gen_count  pipes generated since reset/load (wraps)
//   overflow   sticky, set when an advance request is dropped
// -----------------------------------------------------------------------------
module pipe_height_gen #(
    parameter int          NUM_PIPES  = 4,
    parameter int          Y_W        = 10,
    parameter int          Y_MIN      = 100,
    parameter int          Y_STEP     = 50,
    parameter int          NUM_LEVELS = 4,
    parameter int          MAX_DELTA  = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     advance,
    input  logic                     load,
    input  logic [3:0]               seed_idx,
    input  logic                     rand_mode,
    output logic [NUM_PIPES*Y_W-1:0] pipe_y,
    output logic                     ready,
    output logic [15:0]              gen_count,
    output logic                     overflow
);

    localparam int                K_W      = $clog2(NUM_PIPES);
    localparam logic [K_W-1:0]    K_LAST   = K_W'(NUM_PIPES - 1);
    localparam logic [3:0]        LVL_LAST = 4'(NUM_LEVELS - 1);
    localparam logic [4:0]        NL5      = 5'(NUM_LEVELS);
    localparam logic [7:0]        NL8      = 8'(NUM_LEVELS);
    localparam logic signed [9:0] MAXD_S   = 10'(MAX_DELTA);
    localparam logic signed [9:0] MAXL_S   = 10'(NUM_LEVELS - 1);
    localparam logic [3:0]        RST_LAST = 4'((NUM_PIPES - 1) % NUM_LEVELS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DRAW,
        S_MOD,
        S_CLAMP,
        S_SHIFT
    } state_t;

    state_t         state, state_d;
    logic [K_W-1:0] k, k_d;
    logic [7:0]     rem, rem_d;
    logic [3:0]     lvl, lvl_d;
    logic [3:0]     last_lvl, last_d;
    logic [15:0]    lfsr, lfsr_d;
    logic [15:0]    gen_q, gen_d;
    logic           ovf_q, ovf_d;
    logic           pending, pend_d;
    logic           adv_q;
    logic [Y_W-1:0] pipe_q [NUM_PIPES];
    logic [Y_W-1:0] pipe_d [NUM_PIPES];
    logic [3:0]     fill_lvl;
    logic [7:0]     rem_sub;

    function automatic logic [Y_W-1:0] lvl_to_y(input logic [3:0] l);
        return Y_W'(Y_MIN) + Y_W'(l) * Y_W'(Y_STEP);
    endfunction

    function automatic logic [3:0] seed_lvl(input logic [3:0] s, input logic [4:0] idx);
        logic [4:0] sum;
        sum = {1'b0, s} + idx;
        return 4'(sum % NL5);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Signed window [last-MAX_DELTA, last+MAX_DELTA] intersected with the
    // legal level range; lo may go negative, hence the signed arithmetic.
    function automatic logic [3:0] clamp_lvl(input logic [7:0] r, input logic [3:0] last);
        logic signed [9:0] v, lo, hi;
        v  = signed'({2'b00, r});
        lo = signed'({6'b000000, last}) - MAXD_S;
        hi = signed'({6'b000000, last}) + MAXD_S;
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        if (v < 10'sd0) v = 10'sd0;
        if (v > MAXL_S) v = MAXL_S;
        return v[3:0];
    endfunction

    assign fill_lvl = seed_lvl(seed_idx, 5'(k));
    assign rem_sub  = rem - NL8;

    // State and datapath registers. The advance strobe is registered once so
    // that the FSM and the pending/overflow logic see one aligned request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            k        <= '0;
            rem      <= '0;
            lvl      <= '0;
            last_lvl <= RST_LAST;
            lfsr     <= LFSR_SEED;
            gen_q    <= '0;
            ovf_q    <= 1'b0;
            pending  <= 1'b0;
            adv_q    <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++)
                pipe_q[i] <= lvl_to_y(4'(i % NUM_LEVELS));
        end else begin
            state    <= state_d;
            k        <= k_d;
            rem      <= rem_d;
            lvl      <= lvl_d;
            last_lvl <= last_d;
            lfsr     <= lfsr_d;
            gen_q    <= gen_d;
            ovf_q    <= ovf_d;
            pending  <= pend_d;
            adv_q    <= advance & ~load;
            for (int i = 0; i < NUM_PIPES; i++)
                pipe_q[i] <= pipe_d[i];
        end
    end

    always_comb begin
        state_d = state;
        k_d     = k;
        rem_d   = rem;
        lvl_d   = lvl;
        last_d  = last_lvl;
        lfsr_d  = lfsr;
        gen_d   = gen_q;
        ovf_d   = ovf_q;
        pend_d  = pending;
        for (int i = 0; i < NUM_PIPES; i++)
            pipe_d[i] = pipe_q[i];

        if (state != S_IDLE && load) begin
            // Abort whatever is in flight; nothing partial is committed.
            state_d = S_FILL;
            k_d     = '0;
            pend_d  = 1'b0;
        end else begin
            // One request may wait while busy; a second is dropped.
            if (state != S_IDLE && adv_q) begin
                if (pending) ovf_d  = 1'b1;
                else         pend_d = 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (load) begin
                        state_d = S_FILL;
                        k_d     = '0;
                    end else if (adv_q) begin
                        state_d = S_DRAW;
                    end
                end
                S_FILL: begin
                    pipe_d[k] = lvl_to_y(fill_lvl);
                    if (k == K_LAST) begin
                        last_d  = fill_lvl;
                        gen_d   = '0;
                        pend_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        k_d = k + 1'b1;
                    end
                end
                S_DRAW: begin
                    if (rand_mode) begin
                        lfsr_d  = lfsr_step(lfsr);
                        rem_d   = lfsr_d[7:0];
                        state_d = S_MOD;
                    end else begin
                        rem_d   = (last_lvl == LVL_LAST) ? 8'd0 : {4'd0, last_lvl + 4'd1};
                        state_d = S_CLAMP;
                    end
                end
                S_MOD: begin
                    // Leave as soon as the remainder is in range so a value
                    // of q*NUM_LEVELS+r costs q cycles (min 1).
                    if (rem >= NL8) begin
                        rem_d = rem_sub;
                        if (rem_sub < NL8) state_d = S_CLAMP;
                    end else begin
                        state_d = S_CLAMP;
                    end
                end
                S_CLAMP: begin
                    lvl_d   = clamp_lvl(rem, last_lvl);
                    state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    for (int i = 0; i < NUM_PIPES - 1; i++)
                        pipe_d[i] = pipe_q[i + 1];
                    pipe_d[NUM_PIPES-1] = lvl_to_y(lvl);
                    last_d = lvl;
                    gen_d  = gen_q + 16'd1;
                    // A request arriving on this very cycle continues
                    // straight into the next draw instead of idling.
                    if (pending || adv_q) begin
                        pend_d  = 1'b0;
                        state_d = S_DRAW;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PIPES; i++)
            pipe_y[i*Y_W +: Y_W] = pipe_q[i];
    end

    assign ready     = (state == S_IDLE) && !adv_q;
    assign gen_count = gen_q;
    assign overflow  = ovf_q;

endmodule
